// File: rtl/seg_disp_ctrl_pkg.sv
// seg_pkg: display mode encodings, blank pattern and active-low hex segment table
package seg_pkg;
  localparam logic [1:0] MODE_HEX = 2'b00;
  localparam logic [1:0] MODE_HEX_HI = 2'b01;
  localparam logic [1:0] MODE_RAW = 2'b10;
  localparam logic [1:0] MODE_HEX_LZB = 2'b11;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/seg_disp_ctrl_if.sv
// seg_disp_ctrl_if: CPU display-register bus (cpu_we, cpu_data in; cpu_reg readback out)
interface seg_disp_ctrl_if;
  logic        cpu_we;
  logic [31:0] cpu_data;
  logic [31:0] cpu_reg;
  modport master (output cpu_we, cpu_data, input cpu_reg);
  modport slave (input cpu_we, cpu_data, output cpu_reg);
endinterface

// File: rtl/seg_disp_ctrl_hex_to_seg.sv
// hex_to_seg: combinational nibble (nib) to active-low segment pattern (seg, dp off)
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: multiplexed 7-seg controller; clk/rst, cpu bus, ch_data/sel/mode/blink_en in, AN/SEGMENT out
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_CH = 8,
  parameter int SCAN_BITS = 16,
  parameter int BLINK_BITS = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  seg_disp_ctrl_if.slave              cpu,
  input  logic [(NUM_CH-1)*32-1:0]    ch_data,
  input  logic [$clog2(NUM_CH)-1:0]   sel,
  input  logic [1:0]                  mode,
  input  logic                        blink_en,
  output logic [NUM_DIGITS-1:0]       AN,
  output logic [7:0]                  SEGMENT
);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [31:0] cpu_reg, frame_word, sel_word;
  logic [1:0] frame_mode;
  logic [SCAN_BITS-1:0] scan;
  logic [BLINK_BITS-1:0] blink;
  logic [IW-1:0] idx;
  logic [2:0] d, ni;
  logic [3:0] nib;
  logic [7:0] hex_seg, seg_nxt;
  logic [NUM_DIGITS-1:0] lz;
  logic tick, wrap, z, blank;
  int s;
  assign cpu.cpu_reg = cpu_reg;
  assign tick = &scan;
  assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
  assign d = 3'(idx);
  assign ni = d + ((frame_mode == MODE_HEX_HI && NUM_DIGITS == 4) ? 3'd4 : 3'd0);
  assign nib = frame_word[4*ni +: 4];
  assign blank = blink_en && blink[BLINK_BITS-1];
  hex_to_seg u_hex (.nib(nib), .seg(hex_seg));
  // lz[i]: digit i and every higher displayed nibble are zero
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && frame_word[4*i +: 4] == 4'h0;
      lz[i] = z;
    end
  end
  // out-of-range select falls back to the CPU register
  always_comb begin
    s = int'(sel);
    sel_word = (s == 0 || s >= NUM_CH) ? cpu_reg : ch_data[32*(s-1) +: 32];
  end
  assign seg_nxt = frame_mode == MODE_RAW ? (d[2] ? SEG_BLANK : frame_word[8*d[1:0] +: 8]) :
                   (frame_mode == MODE_HEX_LZB && lz[idx] && idx != '0) ? SEG_BLANK : hex_seg;
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_reg <= '0;
      scan <= '0;
      idx <= '0;
      blink <= '0;
      frame_word <= '0;
      frame_mode <= MODE_HEX;
      AN <= '1;
      SEGMENT <= SEG_BLANK;
    end else begin
      if (cpu.cpu_we) cpu_reg <= cpu.cpu_data;
      scan <= scan + SCAN_BITS'(1);
      blink <= blink + BLINK_BITS'(1);
      if (tick) idx <= wrap ? '0 : idx + IW'(1);
      // new frame content only at the last-digit wrap, so a frame never tears
      if (wrap) begin
        frame_word <= sel_word;
        frame_mode <= mode;
      end
      AN <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
      SEGMENT <= blank ? SEG_BLANK : seg_nxt;
    end
  end
endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for the SOC board. Holds a CPU-writable display register and selects one of NUM_CH 32-bit test/debug channels for display. Drives NUM_DIGITS common-anode digits with time-multiplexed scanning. Adds features the fixed 4-digit display lacks: tear-free frame latching, raw-segment mode, leading-zero blanking and blink.

Parameters:
NUM_DIGITS, 4, digits driven; legal values 4 or 8.
NUM_CH, 8, input channels; channel 0 is always the internal CPU register; power of 2, >=2.
SCAN_BITS, 16, scan prescaler width; the digit advances once every 2^SCAN_BITS clocks.
BLINK_BITS, 24, blink counter width; MSB gives the blink phase.

Ports:
clk  in  1  system clock (CPU clock domain)
rst  in  1  synchronous active-high reset
cpu_we  in  1  load cpu_data into the CPU display register
cpu_data  in  32  CPU write data
ch_data  in  (NUM_CH-1)*32  channels 1..NUM_CH-1, flattened; channel k occupies bits [32k-1:32(k-1)]
sel  in  clog2(NUM_CH)  channel select
mode  in  2  00 hex, 01 hex upper half, 10 raw segments, 11 hex with leading-zero blank
blink_en  in  1  enable blink
AN  out  NUM_DIGITS  digit enables, active-low
SEGMENT  out  8  segments, active-low; bit7 = dp, bits6:0 = g..a
cpu_reg  out  32  current CPU display register, for readback

Behaviour:
- Synchronous active-high reset: all registers clear in the rst cycle. Reset values: cpu_reg=0, scan counter=0, digit index=0, blink counter=0, frame word=0, frame mode=00, AN=all ones, SEGMENT=8'hFF.
- cpu_we: cpu_reg takes cpu_data on the same edge and is visible on cpu_reg the next cycle. cpu_we is honoured even while rst is low only; rst takes priority over cpu_we.
- Scan: the prescaler counts every cycle. tick is asserted when the prescaler is all ones. On tick, the digit index increments modulo NUM_DIGITS.
- Frame latch: on a tick that wraps the digit index from NUM_DIGITS-1 to 0, latch the selected word and mode. The selected word is cpu_reg for sel=0, else channel sel. Changes to sel, mode or the data are visible only from the next frame, so the display never tears.
- Outputs are registered. AN and SEGMENT reflect the digit index with a 1-cycle latency. AN = ~(1<<idx).
- Hex (00): digit d shows nibble d of the frame word. For NUM_DIGITS=4 the low 16 bits are shown.
- Hex upper (01): for NUM_DIGITS=4, digit d shows nibble d+4. For NUM_DIGITS=8 this is identical to 00.
- Leading-zero blank (11): as 00, but a digit is blanked (SEGMENT=8'hFF) if it and all higher displayed nibbles are 0. Digit 0 is never blanked.
- Raw (10): for digit d<4, SEGMENT = byte d of the frame word, passed unchanged. Digits >=4 are blanked.
- In hex modes dp is off (bit7=1).
- Hex encoding, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Blink: the blink counter is free-running. When blink_en=1 and the counter MSB=1, AN is forced all ones and SEGMENT is forced 8'hFF. blink_en is sampled live, not frame-latched.
- Illegal sel >= NUM_CH (possible only if NUM_CH is not a power of 2) selects channel 0.
- Reset mid-scan: the display restarts at digit 0 with frame word 0.

Decomposition:
- Package seg_pkg:
  - mode encodings MODE_HEX, MODE_HEX_HI, MODE_RAW, MODE_HEX_LZB;
  - SEG_BLANK = 8'hFF;
  - 16-entry hex segment table constant.
- Sub-module hex_to_seg: 4-bit nibble in, 8-bit active-low segment pattern out, purely combinational.
- Channel mux, scan and blink counters, frame latch and leading-zero logic live in the top.

Test Plan:
(All with SCAN_BITS=2, BLINK_BITS=6, NUM_DIGITS=4.)
- Reset: hold rst 3 cycles, release. Next cycle AN=4'b1110, SEGMENT=8'hC0; the digit advances every 4 cycles: AN 1101, 1011, 0111, 1110.
- CPU write: cpu_we with cpu_data=32'h0000_A3F1, sel=0, mode=00. After the next frame wrap, digits 0..3 show 8E(1)... exactly digit0=F9, digit1=8E, digit2=B0, digit3=88. cpu_reg=0000A3F1 one cycle after the write.
- Frame latching: change sel from 0 to 2 (ch2=32'h1234_5678) mid-frame. The old word persists until the wrap; then digits show 8, 7, 6, 5 (80, F8, 82, 92). With mode=01 they show 4, 3, 2, 1 (99, B0, A4, F9).
- Leading-zero blank: mode=11, word 0000_0050. Digit0=C0, digit1=92, digits 2 and 3 = FF. Word 0 gives digit0=C0 and the others FF.
- Raw mode: mode=10, word 32'h7F_00_FF_AA. Digit0=AA, digit1=FF, digit2=00, digit3=7F.
- Blink and reset priority: blink_en=1 gives AN=1111 for 32 of every 64 cycles. Asserting rst together with cpu_we=1 leaves cpu_reg=0.
